branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_pkg.sv | 21 ++
 rtl/branch_cmp.sv | 40 ++++
 rtl/branch_resolve_unit.sv | 135 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: compare op-codes and the
// output-register FSM states.
package branch_pkg;

  localparam logic [3:0] OP_EQ  = 4'd0;
  localparam logic [3:0] OP_NE  = 4'd1;
  localparam logic [3:0] OP_GTZ = 4'd2;
  localparam logic [3:0] OP_GEZ = 4'd3;
  localparam logic [3:0] OP_LTZ = 4'd4;
  localparam logic [3:0] OP_LEZ = 4'd5;
  localparam logic [3:0] OP_LT  = 4'd6;
  localparam logic [3:0] OP_LTU = 4'd7;
  localparam logic [3:0] OP_GE  = 4'd8;
  localparam logic [3:0] OP_GEU = 4'd9;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/branch_cmp.sv
// Purely combinational branch condition evaluator; codes 10-15 flag illegal
// and never report taken.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              taken,
  output logic              illegal
);

  logic aNeg;
  logic aZero;

  // Zero-relative compares only need the sign bit and a zero detect.
  assign aNeg  = a[DATA_W-1];
  assign aZero = (a == '0);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_EQ:   taken = (a == b);
      OP_NE:   taken = (a != b);
      OP_GTZ:  taken = !aNeg && !aZero;
      OP_GEZ:  taken = !aNeg;
      OP_LTZ:  taken = aNeg;
      OP_LEZ:  taken = aNeg || aZero;
      OP_LT:   taken = ($signed(a) < $signed(b));
      OP_LTU:  taken = (a < b);
      OP_GE:   taken = ($signed(a) >= $signed(b));
      OP_GEU:  taken = (a >= b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve stage with a one-entry valid/ready output register.
// Optional saturating statistics counters are enabled by BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_target,
  input  logic              in_pred_taken,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic              out_mispredict,
  output logic              out_illegal,
  output logic [ADDR_W-1:0] out_redirect_pc,
  output logic [TAG_W-1:0]  out_tag
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_taken,
  output logic [CNT_W-1:0]  stat_mispredicts
`endif
);

  state_e              state_q, state_d;
  logic                taken_q, taken_d;
  logic                mis_q, mis_d;
  logic                ill_q, ill_d;
  logic [ADDR_W-1:0]   redir_q, redir_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                accept;
  logic                cmpTaken;
  logic                cmpIllegal;

  assign out_valid       = (state_q == ST_FULL);
  assign in_ready        = !out_valid || out_ready;
  assign accept          = in_valid && in_ready;
  assign out_taken       = taken_q;
  assign out_mispredict  = mis_q;
  assign out_illegal     = ill_q;
  assign out_redirect_pc = redir_q;
  assign out_tag         = tag_q;

  branch_cmp #(.DATA_W(DATA_W)) u_cmp (
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .taken  (cmpTaken),
    .illegal(cmpIllegal)
  );

  // Flush wins over a same-cycle accept; the result fields keep their old
  // contents unless a new transaction actually loads.
  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    mis_d   = mis_q;
    ill_d   = ill_q;
    redir_d = redir_q;
    tag_d   = tag_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_FULL;
      taken_d = cmpTaken;
      mis_d   = cmpTaken ^ in_pred_taken;
      ill_d   = cmpIllegal;
      redir_d = cmpTaken ? in_target : in_pc + ADDR_W'(4);
      tag_d   = in_tag;
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      taken_q <= 1'b0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      redir_q <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
      redir_q <= redir_d;
      tag_q   <= tag_d;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic             handshake;
  logic [CNT_W-1:0] branches_q;
  logic [CNT_W-1:0] takenCnt_q;
  logic [CNT_W-1:0] misCnt_q;

  // A result dropped by flush never counts, even if it was being handed off.
  assign handshake        = out_valid && out_ready && !flush;
  assign stat_branches    = branches_q;
  assign stat_taken       = takenCnt_q;
  assign stat_mispredicts = misCnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branches_q <= '0;
      takenCnt_q <= '0;
      misCnt_q   <= '0;
    end else if (handshake) begin
      if (branches_q != '1) branches_q <= branches_q + CNT_W'(1);
      if (taken_q && takenCnt_q != '1) takenCnt_q <= takenCnt_q + CNT_W'(1);
      if (mis_q && misCnt_q != '1) misCnt_q <= misCnt_q + CNT_W'(1);
    end
  end
`else
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit; stat counter checks compile in
// when BRANCH_RESOLVE_STATS_EN is defined.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  typedef struct {
    logic        taken;
    logic        mis;
    logic        ill;
    logic [31:0] redir;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_target = '0;
  logic        in_pred_taken = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_taken;
  logic        out_mispredict;
  logic        out_illegal;
  logic [31:0] out_redirect_pc;
  logic [3:0]  out_tag;

  exp_t sbq[$];
  int   nChecks = 0;
  int   nFails = 0;

  always #5 clk = ~clk;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_branches, stat_taken, stat_mispredicts;
  logic [1:0]  satBranches, satTaken, satMispredicts;
  logic        satInReady, satOutValid, satTakenOut, satMisOut, satIllOut;
  logic [31:0] satRedir;
  logic [3:0]  satTag;
`endif

  branch_resolve_unit #(.DATA_W(32), .ADDR_W(32), .TAG_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_target(in_target),
    .in_pred_taken(in_pred_taken), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .out_illegal(out_illegal),
    .out_redirect_pc(out_redirect_pc), .out_tag(out_tag)
`ifdef BRANCH_RESOLVE_STATS_EN
    , .stat_branches(stat_branches), .stat_taken(stat_taken),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

`ifdef BRANCH_RESOLVE_STATS_EN
  branch_resolve_unit #(.DATA_W(32), .ADDR_W(32), .TAG_W(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(satInReady), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_target(in_target),
    .in_pred_taken(in_pred_taken), .in_tag(in_tag), .flush(flush),
    .out_valid(satOutValid), .out_ready(out_ready), .out_taken(satTakenOut),
    .out_mispredict(satMisOut), .out_illegal(satIllOut),
    .out_redirect_pc(satRedir), .out_tag(satTag),
    .stat_branches(satBranches), .stat_taken(satTaken),
    .stat_mispredicts(satMispredicts)
  );
`endif

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] pc,
                                 input logic [31:0] tgt, input logic pred,
                                 input logic [3:0] tag);
    exp_t e;
    logic t;
    t = 1'b0;
    e.ill = 1'b0;
    case (op)
      OP_EQ:   t = (a == b);
      OP_NE:   t = (a != b);
      OP_GTZ:  t = ($signed(a) > 0);
      OP_GEZ:  t = ($signed(a) >= 0);
      OP_LTZ:  t = ($signed(a) < 0);
      OP_LEZ:  t = ($signed(a) <= 0);
      OP_LT:   t = ($signed(a) < $signed(b));
      OP_LTU:  t = (a < b);
      OP_GE:   t = ($signed(a) >= $signed(b));
      OP_GEU:  t = (a >= b);
      default: e.ill = 1'b1;
    endcase
    e.taken = t;
    e.mis   = t ^ pred;
    e.redir = t ? tgt : pc + 32'd4;
    e.tag   = tag;
    return e;
  endfunction

  // Push expectations on accept, retire them on handshake, drop on flush.
  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) begin
        sbq.delete();
      end else begin
        if (out_valid && out_ready && sbq.size() > 0) void'(sbq.pop_front());
        if (in_valid && in_ready)
          sbq.push_back(model(in_op, in_a, in_b, in_pc, in_target, in_pred_taken, in_tag));
      end
    end
  end

  always @(negedge rst_n) sbq.delete();

  always @(negedge clk) begin
    if (rst_n) begin
      nChecks++;
      if (out_valid !== (sbq.size() != 0)) begin
        nFails++;
        $display("[TB] FAIL sb_valid: out_valid=%b expected=%b", out_valid, sbq.size() != 0);
      end else if (out_valid) begin
        nChecks++;
        if ({out_taken, out_mispredict, out_illegal, out_redirect_pc, out_tag} !==
            {sbq[0].taken, sbq[0].mis, sbq[0].ill, sbq[0].redir, sbq[0].tag}) begin
          nFails++;
          $display("[TB] FAIL sb_result: got t=%b m=%b i=%b pc=%h tag=%0d expected t=%b m=%b i=%b pc=%h tag=%0d",
                   out_taken, out_mispredict, out_illegal, out_redirect_pc, out_tag,
                   sbq[0].taken, sbq[0].mis, sbq[0].ill, sbq[0].redir, sbq[0].tag);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setIn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                       input logic [3:0] tag);
    in_op = op; in_a = a; in_b = b; in_pc = pc; in_target = tgt;
    in_pred_taken = pred; in_tag = tag;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #12;
    nChecks++;
    if ({out_valid, out_taken, out_mispredict, out_illegal, out_redirect_pc, out_tag} !== 38'd0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: got v=%b t=%b m=%b i=%b pc=%h tag=%0d expected all zero",
               out_valid, out_taken, out_mispredict, out_illegal, out_redirect_pc, out_tag);
    end
    nChecks++;
    if (in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_lt_signed;
    @(negedge clk);
    out_ready = 1'b0;
    setIn(OP_LT, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h200, 1'b0, 4'd1);
    in_valid = 1'b1;
    @(posedge clk) #1;
    nChecks++;
    if ({out_valid, out_taken, out_mispredict, out_redirect_pc} !== {1'b1, 1'b1, 1'b1, 32'h200}) begin
      nFails++;
      $display("[TB] FAIL lt_signed: got v=%b t=%b m=%b pc=%h expected v=1 t=1 m=1 pc=00000200",
               out_valid, out_taken, out_mispredict, out_redirect_pc);
    end
    @(negedge clk) in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk) #1;
  endtask

  task automatic test_ltu;
    @(negedge clk);
    setIn(OP_LTU, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h200, 1'b0, 4'd2);
    in_valid = 1'b1;
    @(posedge clk) #1;
    nChecks++;
    if ({out_valid, out_taken, out_mispredict, out_redirect_pc} !== {1'b1, 1'b0, 1'b0, 32'h104}) begin
      nFails++;
      $display("[TB] FAIL ltu: got v=%b t=%b m=%b pc=%h expected v=1 t=0 m=0 pc=00000104",
               out_valid, out_taken, out_mispredict, out_redirect_pc);
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk) #1;
  endtask

  task automatic test_ops;
    logic [31:0] pat [0:5];
    pat[0] = 32'h0000_0000; pat[1] = 32'h0000_0001; pat[2] = 32'hFFFF_FFFF;
    pat[3] = 32'h8000_0000; pat[4] = 32'h7FFF_FFFF; pat[5] = 32'h0000_0001;
    @(negedge clk) out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      setIn(4'(i % 10), pat[$urandom_range(0, 5)], pat[$urandom_range(0, 5)],
            $urandom, $urandom, 1'($urandom_range(0, 1)), 4'(i));
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    out_ready = 1'b0;
    setIn(OP_EQ, 32'd5, 32'd5, 32'h300, 32'h400, 1'b1, 4'd3);
    in_valid = 1'b1;
    @(negedge clk);
    setIn(OP_NE, 32'd5, 32'd6, 32'h500, 32'h600, 1'b0, 4'd4);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk) #1;
      nChecks++;
      if (in_ready !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL stall_in_ready: cycle %0d got %b expected 0", k, in_ready);
      end
      nChecks++;
      if ({out_valid, out_taken, out_mispredict, out_redirect_pc, out_tag} !==
          {1'b1, 1'b1, 1'b0, 32'h400, 4'd3}) begin
        nFails++;
        $display("[TB] FAIL stall_hold: cycle %0d got v=%b t=%b m=%b pc=%h tag=%0d expected 1 1 0 00000400 3",
                 k, out_valid, out_taken, out_mispredict, out_redirect_pc, out_tag);
      end
    end
    @(negedge clk) out_ready = 1'b1;
    #1;
    nChecks++;
    if (in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk) #1;
    nChecks++;
    if ({out_valid, out_taken, out_mispredict, out_redirect_pc, out_tag} !==
        {1'b1, 1'b1, 1'b1, 32'h600, 4'd4}) begin
      nFails++;
      $display("[TB] FAIL back_to_back: got v=%b t=%b m=%b pc=%h tag=%0d expected 1 1 1 00000600 4",
               out_valid, out_taken, out_mispredict, out_redirect_pc, out_tag);
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk) #1;
    nChecks++;
    if (out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_flush;
    @(negedge clk);
    out_ready = 1'b0;
    setIn(OP_EQ, 32'd1, 32'd1, 32'h10, 32'h20, 1'b0, 4'd5);
    in_valid = 1'b1;
    @(negedge clk);
    out_ready = 1'b1; flush = 1'b1;
    setIn(OP_EQ, 32'd2, 32'd2, 32'h30, 32'h40, 1'b0, 4'd6);
    #1;
    nChecks++;
    if (in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL flush_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk) #1;
    nChecks++;
    if (out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL flush_empty: out_valid got %b expected 0", out_valid);
    end
    @(negedge clk) flush = 1'b0; in_valid = 1'b0;
    @(posedge clk) #1;
    nChecks++;
    if (out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL flush_lost: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_illegal_wrap;
    @(negedge clk);
    out_ready = 1'b1;
    setIn(4'd12, 32'd7, 32'd7, 32'h10, 32'h20, 1'b1, 4'd7);
    in_valid = 1'b1;
    @(posedge clk) #1;
    nChecks++;
    if ({out_illegal, out_taken, out_mispredict, out_redirect_pc} !== {1'b1, 1'b0, 1'b1, 32'h14}) begin
      nFails++;
      $display("[TB] FAIL illegal_op: got i=%b t=%b m=%b pc=%h expected 1 0 1 00000014",
               out_illegal, out_taken, out_mispredict, out_redirect_pc);
    end
    @(negedge clk);
    setIn(OP_NE, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'h40, 1'b0, 4'd8);
    @(posedge clk) #1;
    nChecks++;
    if ({out_illegal, out_taken, out_redirect_pc} !== {1'b0, 1'b0, 32'h0}) begin
      nFails++;
      $display("[TB] FAIL pc_wrap: got i=%b t=%b pc=%h expected 0 0 00000000",
               out_illegal, out_taken, out_redirect_pc);
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk) #1;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    out_ready = 1'b0;
    setIn(OP_GEZ, 32'd9, 32'd0, 32'h80, 32'h90, 1'b0, 4'd9);
    in_valid = 1'b1;
    @(posedge clk) #2;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if ({out_valid, out_taken, out_redirect_pc, out_tag} !== 38'd0) begin
      nFails++;
      $display("[TB] FAIL async_reset: got v=%b t=%b pc=%h tag=%0d expected all zero",
               out_valid, out_taken, out_redirect_pc, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    setIn(OP_LTZ, 32'h8000_0000, 32'd0, 32'hA0, 32'hB0, 1'b0, 4'd10);
    @(posedge clk) #1;
    nChecks++;
    if ({out_valid, out_taken, out_tag} !== {1'b1, 1'b1, 4'd10}) begin
      nFails++;
      $display("[TB] FAIL first_accept: got v=%b t=%b tag=%0d expected 1 1 10",
               out_valid, out_taken, out_tag);
    end
    @(negedge clk) in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk) #1;
  endtask

`ifdef BRANCH_RESOLVE_STATS_EN
  task automatic test_stats;
    @(negedge clk) rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      setIn(OP_EQ, 32'(i), 32'(i), 32'h0, 32'h1000, 1'b0, 4'(i));
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if ({stat_branches, stat_taken, stat_mispredicts} !== {32'd5, 32'd5, 32'd5}) begin
      nFails++;
      $display("[TB] FAIL stats_count: got b=%0d t=%0d m=%0d expected 5 5 5",
               stat_branches, stat_taken, stat_mispredicts);
    end
    nChecks++;
    if ({satBranches, satTaken, satMispredicts} !== {2'd3, 2'd3, 2'd3}) begin
      nFails++;
      $display("[TB] FAIL stats_saturate: got b=%0d t=%0d m=%0d expected 3 3 3",
               satBranches, satTaken, satMispredicts);
    end
    @(negedge clk) out_ready = 1'b0; in_valid = 1'b1;
    @(negedge clk) out_ready = 1'b1; flush = 1'b1;
    @(negedge clk) flush = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if (stat_branches !== 32'd5) begin
      nFails++;
      $display("[TB] FAIL stats_flush: stat_branches got %0d expected 5", stat_branches);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lt_signed();
    test_ltu();
    test_ops();
    test_backpressure();
    test_flush();
    test_illegal_wrap();
    test_async_reset();
`ifdef BRANCH_RESOLVE_STATS_EN
    test_stats();
`endif
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
